// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-back, write-allocate data cache controller.
// Define DCACHE_STATS_EN to add the hit_count/miss_count outputs.
module dcache_ctrl #(
    parameter int WORD_SIZE = 32,
    parameter int LINE_SIZE = 128,
    parameter int NUM_LINES = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req_valid,
    input  logic                   req_write,
    input  logic [WORD_SIZE-1:0]   req_addr,
    input  logic [WORD_SIZE-1:0]   req_wdata,
    output logic [WORD_SIZE-1:0]   rdata,
    output logic                   stall,
    output logic                   mem_read,
    output logic                   mem_write,
    output logic [WORD_SIZE-3:0]   mem_addr,
    output logic [LINE_SIZE-1:0]   mem_line_out,
    input  logic [LINE_SIZE-1:0]   mem_line_in,
`ifdef DCACHE_STATS_EN
    output logic [31:0]            hit_count,
    output logic [31:0]            miss_count,
`endif
    input  logic                   mem_ready
);

    localparam int OFF_W = $clog2(LINE_SIZE / WORD_SIZE);
    localparam int IDX_W = $clog2(NUM_LINES);
    localparam int LA_W  = WORD_SIZE - 2 - OFF_W;
    localparam int TAG_W = LA_W - IDX_W;
    localparam int PAD_W = WORD_SIZE - 2 - LA_W;

    typedef enum logic [1:0] {IDLE, WB, GAP, REFILL} state_t;

    state_t               state, state_next;
    logic [LINE_SIZE-1:0] data_q [NUM_LINES];
    logic [TAG_W-1:0]     tag_q  [NUM_LINES];
    logic [NUM_LINES-1:0] valid_q, dirty_q;
    logic [LA_W-1:0]      req_la, miss_la;
    logic [IDX_W-1:0]     req_idx, miss_idx;
    logic [TAG_W-1:0]     req_tag, miss_tag;
    logic [OFF_W-1:0]     req_off;
    logic                 hit;
    logic                 unused_addr_bits;

    assign req_la           = req_addr[WORD_SIZE-1 -: LA_W];
    assign req_off          = req_addr[2 +: OFF_W];
    assign req_idx          = req_la[IDX_W-1:0];
    assign req_tag          = req_la[LA_W-1:IDX_W];
    assign miss_idx         = miss_la[IDX_W-1:0];
    assign miss_tag         = miss_la[LA_W-1:IDX_W];
    assign unused_addr_bits = ^req_addr[1:0];

    always_ff @(posedge clk) begin
        if (!rst) state <= IDLE;
        else      state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (req_valid && !hit)
                         state_next = (valid_q[req_idx] && dirty_q[req_idx]) ? WB : REFILL;
            WB:      if (mem_ready) state_next = GAP;
            GAP:     state_next = REFILL;
            REFILL:  if (mem_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        hit   = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
        stall = (state != IDLE) || (req_valid && !hit);
        rdata = '0;
        if (hit) rdata = data_q[req_idx][int'(req_off)*WORD_SIZE +: WORD_SIZE];
    end

    // Line data and tags are deliberately left untouched by reset; valid/dirty gate them.
    always_ff @(posedge clk) begin
        if (!rst) begin
            valid_q      <= '0;
            dirty_q      <= '0;
            mem_read     <= 1'b0;
            mem_write    <= 1'b0;
            mem_addr     <= '0;
            mem_line_out <= '0;
            miss_la      <= '0;
        end else begin
            case (state)
                IDLE: if (req_valid) begin
                    if (hit) begin
                        if (req_write) begin
                            data_q[req_idx][int'(req_off)*WORD_SIZE +: WORD_SIZE] <= req_wdata;
                            dirty_q[req_idx] <= 1'b1;
                        end
                    end else begin
                        miss_la <= req_la;
                        if (valid_q[req_idx] && dirty_q[req_idx]) begin
                            mem_write    <= 1'b1;
                            mem_addr     <= {{PAD_W{1'b0}}, tag_q[req_idx], req_idx};
                            mem_line_out <= data_q[req_idx];
                        end else begin
                            mem_read <= 1'b1;
                            mem_addr <= {{PAD_W{1'b0}}, req_la};
                        end
                    end
                end
                WB: if (mem_ready) begin
                    mem_write         <= 1'b0;
                    dirty_q[miss_idx] <= 1'b0;
                end
                GAP: begin
                    mem_read <= 1'b1;
                    mem_addr <= {{PAD_W{1'b0}}, miss_la};
                end
                REFILL: if (mem_ready) begin
                    data_q[miss_idx]  <= mem_line_in;
                    tag_q[miss_idx]   <= miss_tag;
                    valid_q[miss_idx] <= 1'b1;
                    dirty_q[miss_idx] <= 1'b0;
                    mem_read          <= 1'b0;
                end
                default: ;
            endcase
        end
    end

`ifdef DCACHE_STATS_EN
    always_ff @(posedge clk) begin
        if (!rst) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else if (state == IDLE && req_valid) begin
            if (hit) hit_count  <= hit_count + 32'd1;
            else     miss_count <= miss_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_dcache_ctrl.sv
// Randomized self-checking bench for dcache_ctrl; the bench also plays the line memory.
// The reference is a flat word memory plus a residency table of which line sits in each slot.
module tb_dcache_ctrl;
    logic         clk = 1'b0;
    logic         rst, req_valid, req_write, stall, mem_read, mem_write, mem_ready;
    logic [31:0]  req_addr, req_wdata, rdata, obs;
    logic [29:0]  mem_addr;
    logic [127:0] mem_line_out, mem_line_in;
`ifdef DCACHE_STATS_EN
    logic [31:0]  hit_count, miss_count;
    int           exp_hits = 0, exp_misses = 0;
`endif
    int           total = 0, bad = 0;
    logic [127:0] mem [16];
    logic [31:0]  gold [64];
    logic         mvalid [4];
    logic         mdirty [4];
    logic [1:0]   mtag [4];

    always #5 clk = ~clk;

    dcache_ctrl #(.WORD_SIZE(32), .LINE_SIZE(128), .NUM_LINES(4)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .rdata(rdata), .stall(stall),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_line_out(mem_line_out), .mem_line_in(mem_line_in),
`ifdef DCACHE_STATS_EN
        .hit_count(hit_count), .miss_count(miss_count),
`endif
        .mem_ready(mem_ready)
    );

    task automatic chk(input string tag, input logic [127:0] observed, input logic [127:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    function automatic logic [127:0] line_of(input int la);
        return {gold[la*4+3], gold[la*4+2], gold[la*4+1], gold[la*4]};
    endfunction

    // After reset the cache forgets everything, so the true contents revert to memory.
    task automatic reset_model();
        for (int i = 0; i < 4; i++) begin
            mvalid[i] = 1'b0;
            mdirty[i] = 1'b0;
            mtag[i]   = 2'b00;
        end
        for (int l = 0; l < 16; l++)
            for (int w = 0; w < 4; w++) gold[l*4+w] = mem[l][w*32 +: 32];
`ifdef DCACHE_STATS_EN
        exp_hits   = 0;
        exp_misses = 0;
`endif
    endtask

    task automatic access(input logic wr, input logic [3:0] la, input logic [1:0] wo,
                          input logic [31:0] wd, output logic [31:0] seen);
        logic [1:0] idx;
        logic [3:0] vla;
        logic       exp_miss, exp_wb, wb_edge, rd_edge, done;
        int         cyc, lat;
        idx      = la[1:0];
        exp_miss = !(mvalid[idx] && mtag[idx] == la[3:2]);
        exp_wb   = exp_miss && mdirty[idx];
        vla      = {mtag[idx], idx};
        wb_edge  = 1'b0;
        rd_edge  = 1'b0;
        done     = 1'b0;
        cyc      = 0;
        lat      = $urandom_range(0, 3);
        seen     = '0;
        @(negedge clk);
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = {24'h0, la, wo, 2'b00};
        req_wdata = wd;
        mem_ready = 1'b0;
        while (!done) begin
            #1;
            chk("rd_wr_exclusive", {mem_read & mem_write}, 1'b0);
            if (cyc == 0) chk("first_stall", stall, exp_miss);
            if (cyc == 1 && exp_miss) chk("mem_op", {mem_write, mem_read}, exp_wb ? 2'b10 : 2'b01);
            if (wb_edge) chk("gap_idle", {mem_write, mem_read}, 2'b00);
            if (rd_edge) chk("refill_then_hit", stall, 1'b0);
            wb_edge = 1'b0;
            rd_edge = 1'b0;
            if (!stall) begin
                seen = rdata;
                if (!wr) chk("rdata", rdata, gold[{la, wo}]);
                else     gold[{la, wo}] = wd;
                mvalid[idx] = 1'b1;
                mtag[idx]   = la[3:2];
                if (wr) mdirty[idx] = 1'b1;
`ifdef DCACHE_STATS_EN
                exp_hits++;
                if (exp_miss) exp_misses++;
`endif
                done = 1'b1;
            end else begin
                mem_ready = 1'b0;
                if (mem_write) begin
                    chk("wb_addr", mem_addr, vla);
                    chk("wb_line", mem_line_out, line_of(vla));
                    if (lat == 0) begin
                        mem_ready   = 1'b1;
                        mem[vla]    = mem_line_out;
                        mdirty[idx] = 1'b0;
                        wb_edge     = 1'b1;
                        lat         = $urandom_range(0, 3);
                    end else lat--;
                end else if (mem_read) begin
                    chk("rd_addr", mem_addr, la);
                    if (lat == 0) begin
                        mem_ready   = 1'b1;
                        mem_line_in = mem[la];
                        rd_edge     = 1'b1;
                        lat         = $urandom_range(0, 3);
                    end else lat--;
                end else if (cyc > 0) begin
                    mem_ready = 1'($urandom_range(0, 1));
                end
            end
            @(posedge clk);
            @(negedge clk);
            cyc++;
            if (!done && cyc > 100) begin
                total++;
                bad++;
                $error("FAIL stall_timeout: observed=%0d cycles expected<=100", cyc);
                done = 1'b1;
            end
        end
        req_valid = 1'b0;
        mem_ready = 1'b0;
    endtask

    initial begin
        rst = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
        mem_ready = 1'b0; mem_line_in = '0;
        for (int l = 0; l < 16; l++) mem[l] = {$urandom, $urandom, $urandom, $urandom};
        mem[1] = 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA;
        reset_model();
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("reset_mem_read", mem_read, 1'b0);
        chk("reset_mem_write", mem_write, 1'b0);
        chk("reset_mem_addr", mem_addr, 30'h0);
        chk("reset_line_out", mem_line_out, 128'h0);
        chk("reset_stall", stall, 1'b0);

        access(1'b0, 4'd1, 2'd0, 32'h0, obs);
        chk("plan_load_10", obs, 32'hAAAAAAAA);
        access(1'b0, 4'd1, 2'd1, 32'h0, obs);
        chk("plan_load_14", obs, 32'hBBBBBBBB);
        access(1'b1, 4'd1, 2'd2, 32'h12345678, obs);
        access(1'b0, 4'd5, 2'd2, 32'h0, obs);
        chk("plan_wb_word2", mem[1][95:64], 32'h12345678);
        access(1'b1, 4'd2, 2'd1, 32'hCAFEF00D, obs);
        access(1'b0, 4'd2, 2'd1, 32'h0, obs);
        chk("plan_store_miss_landed", obs, 32'hCAFEF00D);
        access(1'b0, 4'd6, 2'd0, 32'h0, obs);
        chk("plan_wb_stored_word", mem[2][63:32], 32'hCAFEF00D);
        access(1'b1, 4'd5, 2'd0, 32'h55AA55AA, obs);

        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h000000F0;
        for (int i = 0; i < 5 && !mem_read; i++) @(negedge clk);
        #1;
        chk("mid_refill_read", mem_read, 1'b1);
        rst = 1'b0;
        req_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("abort_mem_read", mem_read, 1'b0);
        chk("abort_stall", stall, 1'b0);
        reset_model();
        access(1'b0, 4'd15, 2'd0, 32'h0, obs);
        access(1'b0, 4'd15, 2'd1, 32'h0, obs);
        access(1'b0, 4'd15, 2'd2, 32'h0, obs);
        access(1'b0, 4'd15, 2'd3, 32'h0, obs);
`ifdef DCACHE_STATS_EN
        #1;
        chk("stats_miss_count", miss_count, 32'd1);
        chk("stats_hit_count", hit_count, 32'd4);
`endif
        access(1'b0, 4'd5, 2'd0, 32'h0, obs);

        for (int n = 0; n < 300; n++)
            access(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                   2'($urandom_range(0, 3)), $urandom, obs);
`ifdef DCACHE_STATS_EN
        #1;
        chk("stats_final_hits", hit_count, exp_hits);
        chk("stats_final_misses", miss_count, exp_misses);
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
